// File: rtl/gcd_engine.sv
// Subtract-and-compare GCD engine: operands A then B are captured on rising edges of Enter,
// Euclid's algorithm runs by repeated subtraction, and Halt/Output hold the result until the next entry.
module gcd_engine #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = WIDTH
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              Enter,
    input  logic [WIDTH-1:0]  Input,
    output logic              Halt,
    output logic [WIDTH-1:0]  Output,
    output logic              Busy,
    output logic [STEP_W-1:0] Steps,
    output logic              ZeroErr
);

    typedef enum logic [1:0] {
        WAIT_A  = 2'd0,
        WAIT_B  = 2'd1,
        COMPUTE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic                enter_q_r;
    logic                rise_s;
    logic [WIDTH-1:0]    x_r, x_s, y_r, y_s, out_r, out_s;
    logic                halt_r, halt_s, busy_r, busy_s, zerr_r, zerr_s;
    logic [STEP_W-1:0]   steps_r, steps_s;

    assign rise_s = Enter & ~enter_q_r;

    // State register
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_r <= WAIT_A;
        end else begin
            state_r <= state_s;
        end
    end

    // Edge detector and datapath registers
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            enter_q_r <= 1'b0;
            x_r       <= {WIDTH{1'b0}};
            y_r       <= {WIDTH{1'b0}};
            out_r     <= {WIDTH{1'b0}};
            halt_r    <= 1'b0;
            busy_r    <= 1'b0;
            zerr_r    <= 1'b0;
            steps_r   <= {STEP_W{1'b0}};
        end else begin
            enter_q_r <= Enter;
            x_r       <= x_s;
            y_r       <= y_s;
            out_r     <= out_s;
            halt_r    <= halt_s;
            busy_r    <= busy_s;
            zerr_r    <= zerr_s;
            steps_r   <= steps_s;
        end
    end

    // Next-state and datapath update; every register holds unless its state acts on it
    always_comb begin
        state_s = state_r;
        x_s     = x_r;
        y_s     = y_r;
        out_s   = out_r;
        halt_s  = halt_r;
        busy_s  = busy_r;
        zerr_s  = zerr_r;
        steps_s = steps_r;
        case (state_r)
            WAIT_A, DONE: begin
                // DONE accepts a new A directly, which is how a restart works without RESET
                if (rise_s) begin
                    x_s     = Input;
                    halt_s  = 1'b0;
                    zerr_s  = 1'b0;
                    steps_s = {STEP_W{1'b0}};
                    state_s = WAIT_B;
                end else begin
                    state_s = state_r;
                end
            end
            WAIT_B: begin
                if (rise_s) begin
                    y_s     = Input;
                    busy_s  = 1'b1;
                    state_s = COMPUTE;
                end else begin
                    state_s = WAIT_B;
                end
            end
            COMPUTE: begin
                if ((x_r == {WIDTH{1'b0}}) || (y_r == {WIDTH{1'b0}})) begin
                    out_s   = x_r | y_r;
                    zerr_s  = (x_r == {WIDTH{1'b0}}) && (y_r == {WIDTH{1'b0}});
                    halt_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = DONE;
                end else if (x_r == y_r) begin
                    out_s   = x_r;
                    halt_s  = 1'b1;
                    busy_s  = 1'b0;
                    state_s = DONE;
                end else begin
                    if (x_r > y_r) begin
                        x_s = x_r - y_r;
                    end else begin
                        y_s = y_r - x_r;
                    end
                    if (steps_r == {STEP_W{1'b1}}) begin
                        steps_s = steps_r;
                    end else begin
                        steps_s = steps_r + {{(STEP_W-1){1'b0}}, 1'b1};
                    end
                    state_s = COMPUTE;
                end
            end
            default: begin
                state_s = WAIT_A;
            end
        endcase
    end

    assign Halt    = halt_r;
    assign Output  = out_r;
    assign Busy    = busy_r;
    assign Steps   = steps_r;
    assign ZeroErr = zerr_r;

endmodule

// File: tb/tb_gcd_engine.sv
// Directed and random bench for gcd_engine with an expected-result queue filled at B entry.
module tb_gcd_engine;

    logic        CLOCK;
    logic        RESET;
    logic        e8, halt8, busy8, zerr8;
    logic [7:0]  in8, out8, steps8;
    logic        e16, halt16, busy16, zerr16;
    logic [15:0] in16, out16, steps16;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [7:0] out;
        logic [7:0] steps;
        logic       zerr;
        int         lat;
    } exp_t;

    exp_t sb[$];

    gcd_engine #(.WIDTH(8), .STEP_W(8)) dut8 (
        .CLOCK(CLOCK), .RESET(RESET), .Enter(e8), .Input(in8),
        .Halt(halt8), .Output(out8), .Busy(busy8), .Steps(steps8), .ZeroErr(zerr8)
    );

    gcd_engine #(.WIDTH(16), .STEP_W(16)) dut16 (
        .CLOCK(CLOCK), .RESET(RESET), .Enter(e16), .Input(in16),
        .Halt(halt16), .Output(out16), .Busy(busy16), .Steps(steps16), .ZeroErr(zerr16)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Euclid by remainder, independent of the subtraction datapath
    function automatic int gcd_ref(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int steps_ref(input int a, input int b);
        int n = 0;
        if (a == 0 || b == 0) return 0;
        while (a != b) begin
            if (a > b) a = a - b;
            else       b = b - a;
            n++;
        end
        return n;
    endfunction

    task automatic enter8(input logic [7:0] v);
        @(negedge CLOCK);
        in8 = v;
        e8  = 1'b1;
        @(negedge CLOCK);
        e8  = 1'b0;
    endtask

    task automatic push_exp(input int a, input int b, input bit with_lat);
        exp_t e;
        e.out   = 8'(gcd_ref(a, b));
        e.steps = 8'(steps_ref(a, b));
        e.zerr  = (a == 0) && (b == 0);
        e.lat   = with_lat ? steps_ref(a, b) + 1 : 0;
        sb.push_back(e);
    endtask

    task automatic wait_check(input string tag);
        int   cyc = 0;
        exp_t e;
        while (!halt8 && cyc < 400) begin
            @(negedge CLOCK);
            cyc++;
        end
        e = sb.pop_front();
        chk({tag, ".halt"}, 32'(halt8), 32'd1);
        chk({tag, ".out"}, 32'(out8), 32'(e.out));
        chk({tag, ".steps"}, 32'(steps8), 32'(e.steps));
        chk({tag, ".zerr"}, 32'(zerr8), 32'(e.zerr));
        chk({tag, ".busy"}, 32'(busy8), 32'd0);
        if (e.lat != 0) chk({tag, ".lat"}, 32'(cyc), 32'(e.lat));
    endtask

    task automatic run_pair(input string tag, input logic [7:0] a, input logic [7:0] b);
        enter8(a);
        enter8(b);
        push_exp(int'(a), int'(b), 1'b1);
        chk({tag, ".busy_start"}, 32'(busy8), 32'd1);
        wait_check(tag);
    endtask

    initial begin
        int cyc;
        logic [7:0] ra, rb;
        RESET = 1'b1;
        e8 = 1'b0; in8 = 8'd0;
        e16 = 1'b0; in16 = 16'd0;
        repeat (3) @(negedge CLOCK);
        chk("rst.halt", 32'(halt8), 32'd0);
        chk("rst.out", 32'(out8), 32'd0);
        chk("rst.busy", 32'(busy8), 32'd0);
        chk("rst.steps", 32'(steps8), 32'd0);
        chk("rst.zerr", 32'(zerr8), 32'd0);
        RESET = 1'b0;

        run_pair("t1", 8'd12, 8'd8);

        run_pair("t2", 8'd255, 8'd1);
        repeat (5) @(negedge CLOCK);
        chk("t2.hold_out", 32'(out8), 32'd1);
        chk("t2.hold_halt", 32'(halt8), 32'd1);

        run_pair("t3a", 8'd0, 8'd9);
        enter8(8'd0);
        chk("t3.restart_halt", 32'(halt8), 32'd0);
        enter8(8'd0);
        push_exp(0, 0, 1'b1);
        wait_check("t3b");

        // Enter held high with a changing bus must capture only the first value
        @(negedge CLOCK);
        in8 = 8'd30;
        e8  = 1'b1;
        @(negedge CLOCK);
        in8 = 8'd77;
        repeat (9) @(negedge CLOCK);
        e8  = 1'b0;
        chk("t4.no_second_capture", 32'(busy8), 32'd0);
        enter8(8'd18);
        push_exp(30, 18, 1'b0);
        @(negedge CLOCK);
        in8 = 8'd5;
        e8  = 1'b1;
        @(negedge CLOCK);
        e8  = 1'b0;
        wait_check("t4");

        enter8(8'd200);
        enter8(8'd3);
        repeat (5) @(negedge CLOCK);
        RESET = 1'b1;
        @(negedge CLOCK);
        chk("t5.halt", 32'(halt8), 32'd0);
        chk("t5.out", 32'(out8), 32'd0);
        chk("t5.busy", 32'(busy8), 32'd0);
        chk("t5.steps", 32'(steps8), 32'd0);
        chk("t5.zerr", 32'(zerr8), 32'd0);
        RESET = 1'b0;
        run_pair("t5b", 8'd21, 8'd14);

        for (int i = 1; i <= 99; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            run_pair($sformatf("t6.%0d", i), ra, rb);
        end

        @(negedge CLOCK);
        in16 = 16'd65535;
        e16  = 1'b1;
        @(negedge CLOCK);
        e16  = 1'b0;
        @(negedge CLOCK);
        in16 = 16'd4369;
        e16  = 1'b1;
        @(negedge CLOCK);
        e16  = 1'b0;
        cyc  = 0;
        while (!halt16 && cyc < 100) begin
            @(negedge CLOCK);
            cyc++;
        end
        chk("w16.halt", 32'(halt16), 32'd1);
        chk("w16.out", 32'(out16), 32'd4369);
        chk("w16.steps", 32'(steps16), 32'd14);
        chk("w16.zerr", 32'(zerr16), 32'd0);
        chk("w16.busy", 32'(busy16), 32'd0);
        chk("w16.lat", 32'(cyc), 32'd15);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
